// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: Mini-MIPS opcode/funct constants, symbolic op enum and loader helpers
package mips_isa_pkg;
  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_NOR, OP_XOR,
    OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_JR, OP_ADDI, OP_ADDIU, OP_ANDI,
    OP_ORI, OP_XORI, OP_LW, OP_SW, OP_LUI, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_LI
  } op_e;
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  function automatic logic [5:0] funct_of(input logic [4:0] op);
    case (op)
      OP_ADD:  return FN_ADD;
      OP_SUB:  return FN_SUB;
      OP_ADDU: return FN_ADDU;
      OP_SUBU: return FN_SUBU;
      OP_AND:  return FN_AND;
      OP_OR:   return FN_OR;
      OP_NOR:  return FN_NOR;
      OP_XOR:  return FN_XOR;
      OP_SLL:  return FN_SLL;
      OP_SRL:  return FN_SRL;
      OP_SRA:  return FN_SRA;
      OP_SLT:  return FN_SLT;
      OP_JR:   return FN_JR;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [5:0] opcode_of(input logic [4:0] op);
    case (op)
      OP_ADDI:  return OPC_ADDI;
      OP_ADDIU: return OPC_ADDIU;
      OP_ANDI:  return OPC_ANDI;
      OP_ORI:   return OPC_ORI;
      OP_XORI:  return OPC_XORI;
      OP_LW:    return OPC_LW;
      OP_SW:    return OPC_SW;
      OP_LUI:   return OPC_LUI;
      OP_BEQ:   return OPC_BEQ;
      OP_BNE:   return OPC_BNE;
      OP_J:     return OPC_J;
      OP_JAL:   return OPC_JAL;
      default:  return OPC_RTYPE;
    endcase
  endfunction

  // Words left between a write pointer and the top of a 2^addr_w memory.
  function automatic int free_slots(input int addr, input int addr_w);
    return (1 << addr_w) - addr;
  endfunction
endpackage

// File: rtl/instr_word_builder.sv
// instr_word_builder: packs one symbolic instruction into one or two MIPS words
module instr_word_builder
  import mips_isa_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [31:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word0,
  output logic [31:0] word1,
  output logic        two_words,
  output logic        legal
);
  logic r_type, j_type, li;
  // Classify by enum range and select the matching encoding format.
  always_comb begin
    r_type    = op <= OP_JR;
    j_type    = op == OP_J || op == OP_JAL;
    li        = op == OP_LI;
    legal     = op <= OP_LI;
    two_words = li && imm[31:16] != 16'h0;
    word1     = {OPC_ORI, rt, rt, imm[15:0]};
    word0     = r_type ? {OPC_RTYPE, rs, rt, rd, shamt, funct_of(op)} :
                j_type ? {opcode_of(op), target} :
                li     ? (two_words ? {OPC_LUI, 5'd0, rt, imm[31:16]} : {OPC_ORI, 5'd0, rt, imm[15:0]}) :
                         {opcode_of(op), (op == OP_LUI) ? 5'd0 : rs, rt, imm[15:0]};
  end
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: accepts symbolic instructions and writes encoded words to instruction memory
module instr_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [31:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              illegal,
  output logic              overflow
);
  typedef enum logic [1:0] {S_IDLE, S_EMIT1, S_EMIT2, S_FULL} state_e;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  state_e      state;
  logic [31:0] word0, word1, pend_word;
  logic        two_words, legal, pend_two, at_last, one_free;

  instr_word_builder u_builder (
    .op(in_op), .rs(in_rs), .rt(in_rt), .rd(in_rd), .shamt(in_shamt),
    .imm(in_imm), .target(in_target),
    .word0(word0), .word1(word1), .two_words(two_words), .legal(legal)
  );

  assign in_ready = state == S_IDLE;
  assign full     = state == S_FULL;
  assign at_last  = mem_addr == LAST_ADDR;
  assign one_free = free_slots(int'(mem_addr), ADDR_W) == 1;

  // Handshake FSM: capture on accept, emit one or two words, stop at the top of memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= BASE;
      mem_wdata  <= '0;
      word_count <= '0;
      illegal    <= 1'b0;
      overflow   <= 1'b0;
      pend_word  <= '0;
      pend_two   <= 1'b0;
    end else if (clear) begin
      state      <= S_IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= BASE;
      mem_wdata  <= '0;
      word_count <= '0;
      illegal    <= 1'b0;
      overflow   <= 1'b0;
      pend_two   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          if (!legal) illegal <= 1'b1;
          else if (two_words && one_free) overflow <= 1'b1;
          else begin
            state     <= S_EMIT1;
            mem_we    <= 1'b1;
            mem_wdata <= word0;
            pend_word <= word1;
            pend_two  <= two_words;
          end
        end
        S_EMIT1, S_EMIT2: if (mem_ready) begin
          word_count <= word_count + 1'b1;
          if (!at_last) mem_addr <= mem_addr + 1'b1;
          if (state == S_EMIT1 && pend_two && !at_last) begin
            state     <= S_EMIT2;
            mem_wdata <= pend_word;
          end else begin
            mem_we <= 1'b0;
            state  <= at_last ? S_FULL : S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed checks of encoding, LI expansion, stalls, full/overflow/illegal and reset
module tb_instr_encoder_loader;
  import mips_isa_pkg::*;
  logic        clk, rst_n;
  logic [4:0]  in_op, in_rs, in_rt, in_rd, in_shamt;
  logic [31:0] in_imm;
  logic [25:0] in_target;
  logic        clear_a, in_valid_a, mem_ready_a, in_ready_a, mem_we_a, full_a, illegal_a, overflow_a;
  logic [7:0]  mem_addr_a;
  logic [8:0]  word_count_a;
  logic [31:0] mem_wdata_a;
  logic        clear_b, in_valid_b, mem_ready_b, in_ready_b, mem_we_b, full_b, illegal_b, overflow_b;
  logic [1:0]  mem_addr_b;
  logic [2:0]  word_count_b;
  logic [31:0] mem_wdata_b;
  int n_pass = 0, n_chk = 0;

  instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_ready(mem_ready_a), .word_count(word_count_a),
    .full(full_a), .illegal(illegal_a), .overflow(overflow_a));

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_ready(mem_ready_b), .word_count(word_count_b),
    .full(full_b), .illegal(illegal_b), .overflow(overflow_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] imm, input logic [25:0] tgt);
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = 5'd0; in_imm = imm; in_target = tgt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear_a = 0; clear_b = 0; in_valid_a = 0; in_valid_b = 0;
    mem_ready_a = 1; mem_ready_b = 1;
    drive(5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 26'd0);
    #3;
    n_chk++; if (mem_we_a !== 1'b0) $display("FAIL reset_we got=%b exp=0", mem_we_a); else n_pass++;
    n_chk++; if (mem_addr_a !== 8'd0) $display("FAIL reset_addr got=%0d exp=0", mem_addr_a); else n_pass++;
    n_chk++; if (mem_wdata_a !== 32'd0) $display("FAIL reset_wdata got=%h exp=0", mem_wdata_a); else n_pass++;
    n_chk++; if (word_count_a !== 9'd0) $display("FAIL reset_count got=%0d exp=0", word_count_a); else n_pass++;
    n_chk++; if ({full_a, illegal_a, overflow_a} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {full_a, illegal_a, overflow_a}); else n_pass++;
    n_chk++; if (in_ready_a !== 1'b1) $display("FAIL reset_ready got=%b exp=1", in_ready_a); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    drive(OP_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 26'd0);
    in_valid_a = 1; tick(); in_valid_a = 0;
    n_chk++; if (mem_we_a !== 1'b1) $display("FAIL add_we got=%b exp=1", mem_we_a); else n_pass++;
    n_chk++; if (mem_addr_a !== 8'd0) $display("FAIL add_addr got=%0d exp=0", mem_addr_a); else n_pass++;
    n_chk++; if (mem_wdata_a !== 32'h00221820) $display("FAIL add_wdata got=%h exp=00221820", mem_wdata_a); else n_pass++;
    n_chk++; if (in_ready_a !== 1'b0) $display("FAIL add_busy got=%b exp=0", in_ready_a); else n_pass++;
    tick();
    n_chk++; if (word_count_a !== 9'd1) $display("FAIL add_count got=%0d exp=1", word_count_a); else n_pass++;
    n_chk++; if (mem_we_a !== 1'b0 || mem_addr_a !== 8'd1) $display("FAIL add_done we=%b addr=%0d exp we=0 addr=1", mem_we_a, mem_addr_a); else n_pass++;
  endtask

  task automatic test_li();
    clear_a = 1; tick(); clear_a = 0;
    n_chk++; if (mem_addr_a !== 8'd0 || word_count_a !== 9'd0) $display("FAIL li_clear addr=%0d cnt=%0d exp 0 0", mem_addr_a, word_count_a); else n_pass++;
    drive(OP_LI, 5'd0, 5'd8, 5'd0, 32'h12345678, 26'd0);
    in_valid_a = 1; tick(); in_valid_a = 0;
    n_chk++; if (mem_we_a !== 1'b1 || mem_addr_a !== 8'd0 || mem_wdata_a !== 32'h3C081234) $display("FAIL li_lui we=%b addr=%0d data=%h exp 1 0 3c081234", mem_we_a, mem_addr_a, mem_wdata_a); else n_pass++;
    tick();
    n_chk++; if (mem_we_a !== 1'b1 || mem_addr_a !== 8'd1 || mem_wdata_a !== 32'h35085678) $display("FAIL li_ori we=%b addr=%0d data=%h exp 1 1 35085678", mem_we_a, mem_addr_a, mem_wdata_a); else n_pass++;
    n_chk++; if (word_count_a !== 9'd1) $display("FAIL li_mid_count got=%0d exp=1", word_count_a); else n_pass++;
    tick();
    n_chk++; if (mem_we_a !== 1'b0 || word_count_a !== 9'd2 || in_ready_a !== 1'b1) $display("FAIL li_done we=%b cnt=%0d rdy=%b exp 0 2 1", mem_we_a, word_count_a, in_ready_a); else n_pass++;
    drive(OP_LI, 5'd0, 5'd8, 5'd0, 32'h0000BEEF, 26'd0);
    in_valid_a = 1; tick(); in_valid_a = 0;
    n_chk++; if (mem_we_a !== 1'b1 || mem_addr_a !== 8'd2 || mem_wdata_a !== 32'h3408BEEF) $display("FAIL li_short we=%b addr=%0d data=%h exp 1 2 3408beef", mem_we_a, mem_addr_a, mem_wdata_a); else n_pass++;
    tick();
    n_chk++; if (mem_we_a !== 1'b0 || word_count_a !== 9'd3) $display("FAIL li_short_done we=%b cnt=%0d exp 0 3", mem_we_a, word_count_a); else n_pass++;
  endtask

  task automatic test_stall();
    mem_ready_a = 0;
    drive(OP_LW, 5'd29, 5'd9, 5'd0, 32'd4, 26'd0);
    in_valid_a = 1; tick(); in_valid_a = 0;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (mem_we_a !== 1'b1 || mem_wdata_a !== 32'h8FA90004 || mem_addr_a !== 8'd3 || in_ready_a !== 1'b0)
        $display("FAIL stall_hold%0d we=%b data=%h addr=%0d rdy=%b exp 1 8fa90004 3 0", i, mem_we_a, mem_wdata_a, mem_addr_a, in_ready_a); else n_pass++;
      if (i < 3) tick();
    end
    mem_ready_a = 1; tick();
    n_chk++; if (mem_we_a !== 1'b0 || mem_addr_a !== 8'd4 || word_count_a !== 9'd4) $display("FAIL stall_done we=%b addr=%0d cnt=%0d exp 0 4 4", mem_we_a, mem_addr_a, word_count_a); else n_pass++;
    drive(OP_J, 5'd0, 5'd0, 5'd0, 32'd0, 26'h10);
    in_valid_a = 1; tick(); in_valid_a = 0;
    n_chk++; if (mem_we_a !== 1'b1 || mem_wdata_a !== 32'h08000010 || mem_addr_a !== 8'd4) $display("FAIL jump we=%b data=%h addr=%0d exp 1 08000010 4", mem_we_a, mem_wdata_a, mem_addr_a); else n_pass++;
    tick();
  endtask

  task automatic test_full();
    drive(OP_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 26'd0);
    for (int k = 0; k < 4; k++) begin
      in_valid_b = 1; tick(); in_valid_b = 0; tick();
    end
    n_chk++; if (full_b !== 1'b1 || in_ready_b !== 1'b0) $display("FAIL full_flag full=%b rdy=%b exp 1 0", full_b, in_ready_b); else n_pass++;
    n_chk++; if (word_count_b !== 3'd4 || mem_addr_b !== 2'd3) $display("FAIL full_count cnt=%0d addr=%0d exp 4 3", word_count_b, mem_addr_b); else n_pass++;
    in_valid_b = 1; tick(); tick(); in_valid_b = 0;
    n_chk++; if (mem_we_b !== 1'b0 || word_count_b !== 3'd4 || full_b !== 1'b1) $display("FAIL full_ignore we=%b cnt=%0d full=%b exp 0 4 1", mem_we_b, word_count_b, full_b); else n_pass++;
    clear_b = 1; tick(); clear_b = 0;
    n_chk++; if (mem_addr_b !== 2'd0 || word_count_b !== 3'd0 || full_b !== 1'b0 || in_ready_b !== 1'b1)
      $display("FAIL full_clear addr=%0d cnt=%0d full=%b rdy=%b exp 0 0 0 1", mem_addr_b, word_count_b, full_b, in_ready_b); else n_pass++;
  endtask

  task automatic test_overflow();
    drive(OP_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 26'd0);
    for (int k = 0; k < 3; k++) begin
      in_valid_b = 1; tick(); in_valid_b = 0; tick();
    end
    n_chk++; if (word_count_b !== 3'd3 || mem_addr_b !== 2'd3) $display("FAIL ovf_pre cnt=%0d addr=%0d exp 3 3", word_count_b, mem_addr_b); else n_pass++;
    drive(OP_LI, 5'd0, 5'd8, 5'd0, 32'h12345678, 26'd0);
    in_valid_b = 1; tick(); in_valid_b = 0;
    n_chk++; if (overflow_b !== 1'b1 || mem_we_b !== 1'b0 || word_count_b !== 3'd3 || in_ready_b !== 1'b1)
      $display("FAIL ovf_flag ovf=%b we=%b cnt=%0d rdy=%b exp 1 0 3 1", overflow_b, mem_we_b, word_count_b, in_ready_b); else n_pass++;
    tick();
    n_chk++; if (mem_we_b !== 1'b0 || overflow_b !== 1'b1) $display("FAIL ovf_sticky we=%b ovf=%b exp 0 1", mem_we_b, overflow_b); else n_pass++;
    drive(5'd27, 5'd0, 5'd0, 5'd0, 32'd0, 26'd0);
    n_chk++; if (illegal_b !== 1'b0) $display("FAIL ill_pre got=%b exp=0", illegal_b); else n_pass++;
    in_valid_b = 1; tick(); in_valid_b = 0;
    n_chk++; if (illegal_b !== 1'b1 || mem_we_b !== 1'b0 || word_count_b !== 3'd3) $display("FAIL ill_flag ill=%b we=%b cnt=%0d exp 1 0 3", illegal_b, mem_we_b, word_count_b); else n_pass++;
    drive(OP_LI, 5'd0, 5'd8, 5'd0, 32'h0000BEEF, 26'd0);
    in_valid_b = 1; tick(); in_valid_b = 0;
    n_chk++; if (mem_we_b !== 1'b1 || mem_addr_b !== 2'd3 || mem_wdata_b !== 32'h3408BEEF) $display("FAIL ovf_last we=%b addr=%0d data=%h exp 1 3 3408beef", mem_we_b, mem_addr_b, mem_wdata_b); else n_pass++;
    tick();
    n_chk++; if (full_b !== 1'b1 || word_count_b !== 3'd4 || mem_we_b !== 1'b0) $display("FAIL ovf_fill full=%b cnt=%0d we=%b exp 1 4 0", full_b, word_count_b, mem_we_b); else n_pass++;
    clear_b = 1; tick(); clear_b = 0;
    n_chk++; if ({illegal_b, overflow_b, full_b} !== 3'b000) $display("FAIL flags_clear got=%b exp=000", {illegal_b, overflow_b, full_b}); else n_pass++;
  endtask

  task automatic test_async_reset();
    clear_a = 1; tick(); clear_a = 0;
    drive(OP_LI, 5'd0, 5'd8, 5'd0, 32'h12345678, 26'd0);
    in_valid_a = 1; tick(); in_valid_a = 0;
    tick();
    n_chk++; if (mem_we_a !== 1'b1 || mem_addr_a !== 8'd1 || mem_wdata_a !== 32'h35085678) $display("FAIL rst_emit2 we=%b addr=%0d data=%h exp 1 1 35085678", mem_we_a, mem_addr_a, mem_wdata_a); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (mem_we_a !== 1'b0 || mem_addr_a !== 8'd0) $display("FAIL rst_async we=%b addr=%0d exp 0 0", mem_we_a, mem_addr_a); else n_pass++;
    rst_n = 1'b1;
    tick();
    n_chk++; if (mem_addr_a !== 8'd0 || word_count_a !== 9'd0 || in_ready_a !== 1'b1 || mem_we_a !== 1'b0)
      $display("FAIL rst_after addr=%0d cnt=%0d rdy=%b we=%b exp 0 0 1 0", mem_addr_a, word_count_a, in_ready_a, mem_we_a); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_li();
    test_stall();
    test_full();
    test_overflow();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Instruction encoder and program loader for the Mini-MIPS core; the write-side counterpart of the instruction decoder. It accepts symbolic instructions (operation code plus register, shift and immediate fields) over a valid/ready handshake and packs them into 32-bit MIPS words. It expands the `li` pseudo-instruction into one or two words. It writes each word into instruction memory at an auto-incrementing word address, so the encodings it produces are exactly those the decoder consumes.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width; capacity 2^ADDR_W words.
- `BASE_ADDR`, 0: first write address after reset or `clear`.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `clear`  in  1: synchronous. Resets the pointer, count, flags and FSM. Priority over all other inputs.
- `in_valid`  in  1: symbolic instruction present.
- `in_ready`  out  1: loader can accept; high only in IDLE.
- `in_op`  in  5: operation enum from `mips_isa_pkg`. 0–24 are real instructions; 25 is LI; 26–31 are illegal.
- `in_rs`, `in_rt`, `in_rd`, `in_shamt`  in  5 each: register and shift fields.
- `in_imm`  in  32: immediate. Bits [15:0] are used, except LI uses all 32 bits.
- `in_target`  in  26: jump target field.
- `mem_we`  out  1: write request to instruction memory.
- `mem_addr`  out  ADDR_W: write word address.
- `mem_wdata`  out  32: encoded word.
- `mem_ready`  in  1: memory accepts the write this cycle.
- `word_count`  out  ADDR_W+1: words written since reset or `clear`.
- `full`  out  1: last address written; no further accepts.
- `illegal`  out  1: sticky; an illegal `in_op` was accepted.
- `overflow`  out  1: sticky; a two-word LI was accepted with only one free slot.

## Operation
- Enum order: ADD, SUB, ADDU, SUBU, AND, OR, NOR, XOR, SLL, SRL, SRA, SLT, JR, ADDI, ADDIU, ANDI, ORI, XORI, LW, SW, LUI, BEQ, BNE, J, JAL, LI.
- R-type encoding:
  - Opcode is 000000.
  - `rs`/`rt`/`rd`/`shamt` are copied verbatim.
  - funct values: add 100000, sub 100010, addu 100001, subu 100011, and 100100, or 100101, nor 100111, xor 100110, sll 000000, srl 000010, sra 000011, slt 101010, jr 001000.
- I-type encoding:
  - Fields: opcode, `rs`, `rt`, `imm[15:0]`.
  - Opcodes: addi 001000, addiu 001001, andi 001100, ori 001101, xori 001110, lw 100011, sw 101011, lui 001111, beq 000100, bne 000101.
  - LUI forces rs=0.
- J-type encoding: j 000010, jal 000011, followed by `in_target`.
- LI with `imm[31:16]==0`: one word, `ori rt,$0,imm[15:0]`.
- LI otherwise: two words, `lui rt,imm[31:16]` then `ori rt,rt,imm[15:0]`.
- FSM states:
  - IDLE: `in_ready=1`. On accept:
    - legal op → EMIT1;
    - illegal op → set `illegal`, stay IDLE;
    - two-word LI with exactly one free slot → set `overflow`, stay IDLE, no write.
  - EMIT1: `mem_we=1` with the first word. On `mem_ready`, the pointer advances. The next state is EMIT2 if a second word is pending, else IDLE. If the last address was just written, the next state is FULL.
  - EMIT2: `mem_we=1` with the ori word. On `mem_ready`, the pointer advances and the next state is IDLE, or FULL if the last address was just written.
  - FULL: `in_ready=0`, `full=1`. Held until `clear`.
- The pointer does not wrap; FULL is entered instead.
- `clear` during EMIT1/EMIT2 aborts the pending write.

## Timing
- Reset values:
  - `mem_we=0`, `mem_addr=BASE_ADDR`, `mem_wdata=0`;
  - `word_count=0`, `full=0`, `illegal=0`, `overflow=0`;
  - state IDLE, so `in_ready=1`.
- Accept happens on the rising edge where `in_valid && in_ready`.
- The first word appears on `mem_*` in the following cycle (latency 1).
- `mem_we`, `mem_addr` and `mem_wdata` are registered and held stable while `mem_ready=0`.
- A write completes on the edge where `mem_we && mem_ready`:
  - `mem_addr` and `word_count` increment on that edge;
  - `mem_we` drops next cycle unless EMIT2 follows, in which case it stays high with the new address and word.
- Peak throughput: one word per 2 cycles; LI takes 3 cycles with no stalls.
- `rst_n` low at any time forces all reset values immediately, including mid-LI.

## Structure
- `mips_isa_pkg` holds:
  - opcode and funct constants, shared with the decoder;
  - the `in_op` enum;
  - a `FREE_SLOTS` helper.
- One combinational sub-module, `instr_word_builder`:
  - inputs: op and fields;
  - outputs: `word0`, `word1`, `two_words`, `legal`.
- The FSM, pointer and flags live in `instr_encoder_loader`.

## Test plan
- ADD rs=1 rt=2 rd=3 with `mem_ready=1` → one cycle later `mem_we=1`, `mem_addr=0`, `mem_wdata=0x00221820`; `word_count=1`.
- LI rt=8 imm=0x12345678 → 0x3C081234 @0, then 0x35085678 @1. LI rt=8 imm=0x0000BEEF → single 0x3408BEEF.
- LW rs=29 rt=9 imm=4, with `mem_ready` low 3 cycles → 0x8FA90004 held stable 4 cycles, `in_ready=0` throughout. Then J target 0x10 → 0x08000010.
- ADDR_W=2: four ADDs → `full=1`, `in_ready=0`, fifth `in_valid` ignored. `clear` → `mem_addr=0`, `word_count=0`, `full=0`.
- ADDR_W=2: three words, then LI 0x12345678 → `overflow=1`, no `mem_we`, `word_count=3`. Then `in_op=27` → `illegal=1`, no write.
- `rst_n` pulsed low during EMIT2 of an LI → `mem_we=0` asynchronously. After release: `mem_addr=BASE_ADDR`, `word_count=0`, `in_ready=1`.
